fifo_ctrl: RTL and testbench
============================

FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 The parameter DATA_W SHALL default to 8 and set the width of the data path into the 16x8 dual-port RAM.
REQ-002 The parameter ADDR_W SHALL default to 4 and set the RAM address width, giving a depth of 2^ADDR_W = 16.
REQ-003 The parameter AF_LEVEL SHALL default to 14 and set the almost_full threshold in entries.
REQ-004 The parameter AE_LEVEL SHALL default to 2 and set the almost_empty threshold in entries.
REQ-005 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-006 Port rst SHALL be an input, 1 bit wide: the reset, synchronous and active-high.
REQ-007 Port push SHALL be an input, 1 bit wide: the write request from the producer.
REQ-008 Port din SHALL be an input, DATA_W bits wide: the write data from the producer.
REQ-009 Port pop SHALL be an input, 1 bit wide: the read request from the consumer.
REQ-010 Port ram_d_in SHALL be an output, DATA_W bits wide, and drive the RAM d_in.
REQ-011 Port ram_wr_addr SHALL be an output, ADDR_W bits wide, and drive the RAM wr_addr.
REQ-012 Port ram_wr SHALL be an output, 1 bit wide, and drive the RAM wr.
REQ-013 Port ram_re_addr SHALL be an output, ADDR_W bits wide, and drive the RAM re_addr.
REQ-014 Port ram_re SHALL be an output, 1 bit wide, and drive the RAM re.
REQ-015 Port rd_valid SHALL be an output, 1 bit wide: RAM d_out carries popped data this cycle.
REQ-016 The status outputs SHALL be: full, empty, almost_full, almost_empty (1 bit each) and count (ADDR_W+1 bits).
REQ-017 Port overflow SHALL be an output, 1 bit wide: a one-cycle pulse marking a rejected push.
REQ-018 Port underflow SHALL be an output, 1 bit wide: a one-cycle pulse marking a rejected pop.

Function
REQ-019 wr_ptr and rd_ptr SHALL each be ADDR_W+1 bits wide: the low ADDR_W bits address the RAM and the MSB is a wrap bit.
REQ-020 push_acc SHALL equal push AND NOT full AND NOT rst; pop_acc SHALL equal pop AND NOT empty AND NOT rst.
REQ-021 ram_wr SHALL equal push_acc, ram_wr_addr SHALL equal wr_ptr[ADDR_W-1:0], and ram_d_in SHALL equal din, all combinationally, so that the RAM writes on the same edge.
REQ-022 ram_re SHALL equal pop_acc and ram_re_addr SHALL equal rd_ptr[ADDR_W-1:0], both combinationally.
REQ-023 On each edge, push_acc SHALL increment wr_ptr by 1 and pop_acc SHALL increment rd_ptr by 1, both modulo 2^(ADDR_W+1).
REQ-024 count SHALL be a register updated as follows: +1 on push_acc only, -1 on pop_acc only, unchanged when both or neither are accepted; its range is 0..16.
REQ-025 empty SHALL be asserted when wr_ptr equals rd_ptr.
REQ-026 full SHALL be asserted when the pointer MSBs differ and the low bits are equal.
REQ-027 empty and full SHALL never be asserted together.
REQ-028 almost_full SHALL equal (count >= AF_LEVEL) and almost_empty SHALL equal (count <= AE_LEVEL), both combinationally from count.
REQ-029 rd_valid SHALL be registered and equal pop_acc delayed by 1 cycle, aligned with the RAM's registered d_out, giving a read latency of 1 clock.
REQ-030 Push and pop together when 0 < count < 16 SHALL both be accepted; count is unchanged and both pointers advance.
REQ-031 Push and pop together when empty SHALL accept the push only; underflow pulses and count goes 0 to 1.
REQ-032 Push and pop together when full SHALL accept the pop only; overflow pulses and count goes 16 to 15.
REQ-033 overflow SHALL be registered and equal (push AND full AND NOT rst) delayed by 1 cycle.
REQ-034 underflow SHALL be registered and equal (pop AND empty AND NOT rst) delayed by 1 cycle.
REQ-035 Pointer wrap from 15 to 16 (low bits 1111 to 0000) SHALL be seamless, with no gap in addressing and no spurious flag.

Reset
REQ-036 While rst is high at an edge, wr_ptr, rd_ptr and count SHALL become 0, and rd_valid, overflow and underflow SHALL become 0; consequently empty=1, full=0, almost_empty=1 and almost_full=0.
REQ-037 While rst is high, ram_wr and ram_re SHALL be 0 regardless of push and pop, and reset SHALL have priority over any operation in flight.
REQ-038 A reset asserted mid-operation SHALL discard all stored entries; any rd_valid pending from a pop in the pre-reset cycle SHALL be cleared by reset.

Verification
REQ-039 After reset, push 0xA5 for one cycle -> ram_wr=1, ram_wr_addr=0 and ram_d_in=0xA5 in that cycle; next cycle count=1 and empty=0.
REQ-040 Push 0x11, 0x22 and 0x33, then pop three times -> rd_valid high on 3 consecutive cycles with RAM d_out 0x11, 0x22, 0x33; then empty=1 and count=0.
REQ-041 Push 16 values -> full=1, count=16, almost_full first asserted at count=14; a 17th push -> ram_wr=0, overflow pulses for 1 cycle, count stays 16.
REQ-042 Pop while empty -> ram_re=0, underflow pulses for 1 cycle, rd_valid stays 0.
REQ-043 Push and pop together at count=16 -> count=15 and overflow=1; push and pop together at count=0 -> count=1 and underflow=1; at count=5 -> count stays 5.
REQ-044 Fill 10 entries, drain 10, refill 10 to force a wrap -> ram_wr_addr runs 10..15 then 0..3, data read back matches in order, and rst asserted at count=7 -> count=0 and empty=1 on the next edge.

Source files
------------

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, count and flag control for a 2^ADDR_W-deep FIFO built around an external dual-port RAM
module fifo_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] ram_d_in,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_re_addr,
  output logic              ram_re,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] AF  = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE  = (ADDR_W+1)'(AE_LEVEL);
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic            rd_valid_q, overflow_q, underflow_q, push_acc, pop_acc;
  always_comb begin
    empty        = wr_ptr_q == rd_ptr_q;
    full         = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) && (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    push_acc     = push && !full && !rst;
    pop_acc      = pop && !empty && !rst;
    wr_ptr_d     = push_acc ? wr_ptr_q + ONE : wr_ptr_q;
    rd_ptr_d     = pop_acc ? rd_ptr_q + ONE : rd_ptr_q;
    count_d      = (push_acc && !pop_acc) ? count_q + ONE :
                   (pop_acc && !push_acc) ? count_q - ONE : count_q;
    ram_wr       = push_acc;
    ram_wr_addr  = wr_ptr_q[ADDR_W-1:0];
    ram_d_in     = din;
    ram_re       = pop_acc;
    ram_re_addr  = rd_ptr_q[ADDR_W-1:0];
    count        = count_q;
    almost_full  = count_q >= AF;
    almost_empty = count_q <= AE;
    rd_valid     = rd_valid_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= pop_acc;
      overflow_q  <= push && full;
      underflow_q <= pop && empty;
    end
  end
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: queue-based reference model checking fifo_ctrl with a behavioural RAM attached
module tb_fifo_ctrl;
  logic clk = 1'b0, rst = 1'b1, push = 1'b0, pop = 1'b0;
  logic [7:0] din = '0, ram_d_in, ram_dout;
  logic [3:0] ram_wr_addr, ram_re_addr;
  logic ram_wr, ram_re, rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  logic [7:0] mem [16];
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  int m_wr_n = 0, m_rd_n = 0;
  logic m_ovf = 0, m_udf = 0, m_rv = 0;
  logic [7:0] m_pop_val = '0;
  logic s_wr, s_re;
  logic [3:0] s_wa, s_ra;
  logic [7:0] s_di;
  int e_wa, e_ra;
  logic e_wr, e_re;

  fifo_ctrl dut (
    .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop),
    .ram_d_in(ram_d_in), .ram_wr_addr(ram_wr_addr), .ram_wr(ram_wr),
    .ram_re_addr(ram_re_addr), .ram_re(ram_re), .rd_valid(rd_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr) mem[ram_wr_addr] <= ram_d_in;
    if (ram_re) ram_dout <= mem[ram_re_addr];
  end

  function automatic logic [11:0] exp_status();
    int sz = q.size();
    return {sz == 16, sz == 0, sz >= 14, sz <= 2, 5'(sz), m_ovf, m_udf, m_rv};
  endfunction

  task automatic cycle(input logic p, input logic [7:0] d, input logic r, input logic rs);
    int sz;
    push = p; din = d; pop = r; rst = rs;
    #1;
    s_wr = ram_wr; s_wa = ram_wr_addr; s_di = ram_d_in; s_re = ram_re; s_ra = ram_re_addr;
    sz = q.size();
    e_wr = p && sz < 16 && !rs;
    e_re = r && sz > 0 && !rs;
    e_wa = m_wr_n % 16;
    e_ra = m_rd_n % 16;
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete(); m_wr_n = 0; m_rd_n = 0; m_ovf = 0; m_udf = 0; m_rv = 0;
    end else begin
      if (e_re) begin m_pop_val = q.pop_front(); m_rd_n++; end
      if (e_wr) begin q.push_back(d); m_wr_n++; end
      m_ovf = p && sz == 16;
      m_udf = r && sz == 0;
      m_rv = e_re;
    end
  endtask

  task automatic test_reset();
    cycle(1, 8'hFF, 1, 1);
    cycle(1, 8'hFF, 1, 1);
    checks++; if ({s_wr, s_re} !== 2'b00) begin errors++; $display("FAIL reset_ram_ctl got %b exp 00", {s_wr, s_re}); end
    checks++; if ({full, empty, almost_full, almost_empty, count, overflow, underflow, rd_valid} !== 12'b0101_00000_000) begin
      errors++; $display("FAIL reset_state got %b exp 010100000000", {full, empty, almost_full, almost_empty, count, overflow, underflow, rd_valid}); end
  endtask

  task automatic test_single_push();
    cycle(0, 0, 0, 1);
    cycle(1, 8'hA5, 0, 0);
    checks++; if ({s_wr, s_wa, s_di} !== {1'b1, 4'd0, 8'hA5}) begin errors++; $display("FAIL push_ram got wr=%b addr=%0d d=%h exp 1 0 a5", s_wr, s_wa, s_di); end
    checks++; if ({count, empty} !== {5'd1, 1'b0}) begin errors++; $display("FAIL push_count got count=%0d empty=%b exp 1 0", count, empty); end
  endtask

  task automatic test_order();
    logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, vals[i], 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 0);
      checks++; if ({rd_valid, ram_dout} !== {1'b1, vals[i]}) begin errors++; $display("FAIL order_%0d got rv=%b d=%h exp 1 %h", i, rd_valid, ram_dout, vals[i]); end
    end
    cycle(0, 0, 0, 0);
    checks++; if ({rd_valid, empty, count} !== {1'b0, 1'b1, 5'd0}) begin errors++; $display("FAIL order_drained got rv=%b empty=%b count=%0d exp 0 1 0", rd_valid, empty, count); end
  endtask

  task automatic test_full();
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      cycle(1, 8'(i * 7 + 3), 0, 0);
      checks++; if (almost_full !== (i + 1 >= 14)) begin errors++; $display("FAIL af_at_%0d got %b exp %b", i + 1, almost_full, i + 1 >= 14); end
    end
    checks++; if ({full, count} !== {1'b1, 5'd16}) begin errors++; $display("FAIL full got full=%b count=%0d exp 1 16", full, count); end
    cycle(1, 8'hEE, 0, 0);
    checks++; if ({s_wr, overflow, count} !== {1'b0, 1'b1, 5'd16}) begin errors++; $display("FAIL overflow got wr=%b ovf=%b count=%0d exp 0 1 16", s_wr, overflow, count); end
    cycle(0, 0, 0, 0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_pulse got %b exp 0", overflow); end
  endtask

  task automatic test_underflow();
    cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 0);
    checks++; if ({s_re, underflow, rd_valid} !== 3'b010) begin errors++; $display("FAIL underflow got re=%b udf=%b rv=%b exp 0 1 0", s_re, underflow, rd_valid); end
    cycle(0, 0, 0, 0);
    checks++; if ({underflow, rd_valid} !== 2'b00) begin errors++; $display("FAIL underflow_pulse got udf=%b rv=%b exp 0 0", underflow, rd_valid); end
  endtask

  task automatic test_simultaneous();
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) cycle(1, 8'(i), 0, 0);
    cycle(1, 8'h99, 1, 0);
    checks++; if ({count, overflow} !== {5'd15, 1'b1}) begin errors++; $display("FAIL both_full got count=%0d ovf=%b exp 15 1", count, overflow); end
    for (int i = 0; i < 15; i++) cycle(0, 0, 1, 0);
    cycle(1, 8'h42, 1, 0);
    checks++; if ({count, underflow} !== {5'd1, 1'b1}) begin errors++; $display("FAIL both_empty got count=%0d udf=%b exp 1 1", count, underflow); end
    for (int i = 0; i < 4; i++) cycle(1, 8'(i + 1), 0, 0);
    cycle(1, 8'h77, 1, 0);
    checks++; if ({count, ram_dout} !== {5'd5, 8'h42}) begin errors++; $display("FAIL both_mid got count=%0d d=%h exp 5 42", count, ram_dout); end
  endtask

  task automatic test_wrap();
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cycle(1, 8'(8'h50 + i), 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 8'(8'hC0 + i), 0, 0);
      checks++; if (s_wa !== 4'((10 + i) % 16)) begin errors++; $display("FAIL wrap_addr_%0d got %0d exp %0d", i, s_wa, (10 + i) % 16); end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 0);
      checks++; if ({rd_valid, ram_dout} !== {1'b1, 8'(8'hC0 + i)}) begin errors++; $display("FAIL wrap_data_%0d got rv=%b d=%h exp 1 %h", i, rd_valid, ram_dout, 8'(8'hC0 + i)); end
    end
    checks++; if (count !== 5'd7) begin errors++; $display("FAIL wrap_count got %0d exp 7", count); end
    cycle(1, 8'h01, 1, 0);
    cycle(0, 0, 0, 1);
    checks++; if ({count, empty, rd_valid} !== {5'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL mid_reset got count=%0d empty=%b rv=%b exp 0 1 0", count, empty, rd_valid); end
  endtask

  task automatic test_random();
    logic [11:0] st;
    cycle(0, 0, 0, 1);
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 99) < (n % 100 < 50 ? 70 : 30), 8'($urandom), $urandom_range(0, 99) < (n % 100 < 50 ? 30 : 70), $urandom_range(0, 59) == 0);
      checks++; if ({s_wr, s_re, s_wa, s_ra} !== {e_wr, e_re, 4'(e_wa), 4'(e_ra)}) begin errors++; $display("FAIL rand_ram_%0d got %b exp %b", n, {s_wr, s_re, s_wa, s_ra}, {e_wr, e_re, 4'(e_wa), 4'(e_ra)}); end
      st = exp_status();
      checks++; if ({full, empty, almost_full, almost_empty, count, overflow, underflow, rd_valid} !== st) begin
        errors++; $display("FAIL rand_status_%0d got %b exp %b", n, {full, empty, almost_full, almost_empty, count, overflow, underflow, rd_valid}, st); end
      if (m_rv) begin
        checks++; if (ram_dout !== m_pop_val) begin errors++; $display("FAIL rand_data_%0d got %h exp %h", n, ram_dout, m_pop_val); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_order();
    test_full();
    test_underflow();
    test_simultaneous();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
